// File: rtl/cascade_counter.sv
// Cascaded multi-stage digit counter with per-stage moduli, up/down stepping,
// range-checked parallel load, optional saturation at the limit, and an alarm compare.
module cascade_counter #(
    parameter int                     STAGES   = 4,
    parameter int                     DW       = 6,
    parameter logic [STAGES*DW-1:0]   MODS     = {6'd24, 6'd60, 6'd60, 6'd10},
    parameter bit                     SATURATE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   dir,
    input  logic                   load,
    input  logic [STAGES*DW-1:0]   load_val,
    input  logic [STAGES*DW-1:0]   alarm_val,
    output logic [STAGES*DW-1:0]   cnt,
    output logic [STAGES-1:0]      co,
    output logic                   at_limit,
    output logic                   load_err,
    output logic                   alarm
);

    for (genvar g = 0; g < STAGES; g++) begin : g_mod_check
        if (MODS[g*DW +: DW] < DW'(2)) begin : g_bad_mod
            $error("cascade_counter: every stage modulus must be at least 2");
        end
    end

    logic [STAGES*DW-1:0] r_cnt;
    logic                 r_load_err;
    logic                 r_alarm;
    logic                 r_match_q;

    logic [STAGES-1:0]    w_term;
    logic [STAGES-1:0]    w_pref;
    logic [STAGES-1:0]    w_bad;
    logic [STAGES-1:0]    w_co;
    logic [STAGES*DW-1:0] w_load;
    logic [STAGES*DW-1:0] w_next;
    logic                 w_hold;
    logic                 w_adv;
    logic                 w_match;

    // NOTE: every signal gets a default before the loops, so no path leaves a latch.
    always_comb begin
        logic [DW-1:0] v_cur;
        logic [DW-1:0] v_mod;
        logic          v_run;
        logic          v_carry;

        w_term  = '0;
        w_pref  = '0;
        w_bad   = '0;
        w_co    = '0;
        w_load  = '0;
        w_next  = r_cnt;
        v_cur   = '0;
        v_mod   = '0;
        v_run   = 1'b1;

        for (int i = 0; i < STAGES; i++) begin
            v_cur     = r_cnt[i*DW +: DW];
            v_mod     = MODS[i*DW +: DW];
            w_term[i] = dir ? (v_cur == v_mod - 1'b1) : (v_cur == '0);
            v_run     = v_run & w_term[i];
            w_pref[i] = v_run;
            w_bad[i]  = (load_val[i*DW +: DW] >= v_mod);
            w_load[i*DW +: DW] = w_bad[i] ? '0 : load_val[i*DW +: DW];
        end

        w_hold  = SATURATE & w_pref[STAGES-1] & en;
        w_adv   = en & ~w_hold & ~load;
        v_carry = w_adv;

        // Ripple the step enable upward; a stage moves only when all lower stages are terminal.
        for (int i = 0; i < STAGES; i++) begin
            v_cur = r_cnt[i*DW +: DW];
            v_mod = MODS[i*DW +: DW];
            if (v_carry) begin
                if (dir) begin
                    w_next[i*DW +: DW] = w_term[i] ? '0 : v_cur + 1'b1;
                end else begin
                    w_next[i*DW +: DW] = w_term[i] ? v_mod - 1'b1 : v_cur - 1'b1;
                end
            end
            v_carry = v_carry & w_term[i];
            w_co[i] = v_carry;
        end
    end

    assign w_match = (r_cnt == alarm_val);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_load_err <= 1'b0;
            r_alarm    <= 1'b0;
            r_match_q  <= 1'b1;
        end else begin
            r_match_q  <= w_match;
            r_alarm    <= w_match & ~r_match_q;
            r_load_err <= load & (|w_bad);
            r_cnt      <= load ? w_load : w_next;
        end
    end

    assign cnt      = r_cnt;
    assign co       = w_co;
    assign at_limit = w_pref[STAGES-1];
    assign load_err = r_load_err;
    assign alarm    = r_alarm;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter: a wrap and a saturating instance share stimulus and are
// checked against a mixed-radix integer model through a scoreboard plus a vector table.
module tb_cascade_counter;

    localparam int STAGES = 4;
    localparam int DW     = 6;
    localparam int W      = STAGES * DW;
    localparam logic [W-1:0] MODS = {6'd24, 6'd60, 6'd60, 6'd10};
    localparam int TOT    = 864000;
    localparam int MOD_T [STAGES] = '{10, 60, 60, 24};
    localparam int PROD  [STAGES] = '{10, 600, 36000, 864000};

    logic              clk = 1'b0;
    logic              rst, en, dir, load;
    logic [W-1:0]      load_val, alarm_val;
    logic [W-1:0]      cnt_w, cnt_s;
    logic [STAGES-1:0] co_w, co_s;
    logic              lim_w, lim_s, err_w, err_s, alm_w, alm_s;

    always #5 clk = ~clk;

    cascade_counter #(.STAGES(STAGES), .DW(DW), .MODS(MODS), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .alarm_val(alarm_val),
        .cnt(cnt_w), .co(co_w), .at_limit(lim_w), .load_err(err_w), .alarm(alm_w)
    );

    cascade_counter #(.STAGES(STAGES), .DW(DW), .MODS(MODS), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .alarm_val(alarm_val),
        .cnt(cnt_s), .co(co_s), .at_limit(lim_s), .load_err(err_s), .alarm(alm_s)
    );

    typedef struct {
        logic        rst, load, en, dir;
        logic [W-1:0] lv, av;
        bit          chk;
        bit          tgt;
        logic [3:0]  co;
        logic        lim;
        logic [W-1:0] cnt;
        logic        err, alm;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt_w, cnt_s;
        logic         err_w, err_s, alm_w, alm_s;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_n   [2];
    logic m_err [2];
    logic m_alm [2];
    logic m_mq  [2];
    exp_t sb [$];
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
        return {DW'(a), DW'(b), DW'(c), DW'(d)};
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = STAGES - 1; i >= 0; i--) n = n * MOD_T[i] + int'(v[i*DW +: DW]);
        return n;
    endfunction

    function automatic logic [W-1:0] from_int(input int n);
        logic [W-1:0] r;
        int x;
        x = n;
        r = '0;
        for (int i = 0; i < STAGES; i++) begin
            r[i*DW +: DW] = DW'(x % MOD_T[i]);
            x = x / MOD_T[i];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic l, input logic e, input logic d,
                                input logic [W-1:0] lv, input logic [W-1:0] av,
                                input bit tgt, input logic [3:0] co, input logic lim,
                                input logic [W-1:0] cnt, input logic err, input logic alm);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.dir = d; v.lv = lv; v.av = av;
        v.chk = 1'b1; v.tgt = tgt; v.co = co; v.lim = lim; v.cnt = cnt; v.err = err; v.alm = alm;
        return v;
    endfunction

    // One clock: drive, check combinational outputs, predict, clock, check registered outputs.
    task automatic cycle(input vec_t v);
        exp_t         e;
        logic [3:0]   mco;
        logic [W-1:0] lv_c;
        logic         mlim, hold, adv, match, bad;
        int           f;

        rst = v.rst; load = v.load; en = v.en; dir = v.dir;
        load_val = v.lv; alarm_val = v.av;
        #1;
        for (int k = 0; k < 2; k++) begin
            mlim = v.dir ? (m_n[k] == TOT - 1) : (m_n[k] == 0);
            hold = (k == 1) && mlim && v.en;
            adv  = v.en && !hold && !v.load;
            for (int i = 0; i < STAGES; i++)
                mco[i] = adv && (v.dir ? (m_n[k] % PROD[i] == PROD[i] - 1) : (m_n[k] % PROD[i] == 0));
            check(k == 0 ? "co_w" : "co_s", k == 0 ? co_w : co_s, mco);
            check(k == 0 ? "at_limit_w" : "at_limit_s", k == 0 ? lim_w : lim_s, mlim);

            if (v.rst) begin
                m_n[k] = 0; m_err[k] = 1'b0; m_alm[k] = 1'b0; m_mq[k] = 1'b1;
            end else begin
                match    = (from_int(m_n[k]) == v.av);
                m_alm[k] = match && !m_mq[k];
                m_mq[k]  = match;
                if (v.load) begin
                    bad  = 1'b0;
                    lv_c = '0;
                    for (int i = 0; i < STAGES; i++) begin
                        f = int'(v.lv[i*DW +: DW]);
                        if (f >= MOD_T[i]) begin
                            bad = 1'b1;
                            f   = 0;
                        end
                        lv_c[i*DW +: DW] = DW'(f);
                    end
                    m_n[k]   = to_int(lv_c);
                    m_err[k] = bad;
                end else begin
                    m_err[k] = 1'b0;
                    if (adv) m_n[k] = v.dir ? (m_n[k] + 1) % TOT : (m_n[k] + TOT - 1) % TOT;
                end
            end
        end
        if (v.chk) begin
            check("tbl_co", v.tgt ? co_s : co_w, v.co);
            check("tbl_at_limit", v.tgt ? lim_s : lim_w, v.lim);
        end
        e.cnt_w = from_int(m_n[0]); e.err_w = m_err[0]; e.alm_w = m_alm[0];
        e.cnt_s = from_int(m_n[1]); e.err_s = m_err[1]; e.alm_s = m_alm[1];
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cnt_w", cnt_w, e.cnt_w);
        check("load_err_w", err_w, e.err_w);
        check("alarm_w", alm_w, e.alm_w);
        check("cnt_s", cnt_s, e.cnt_s);
        check("load_err_s", err_s, e.err_s);
        check("alarm_s", alm_s, e.alm_s);
        if (v.chk) begin
            check("tbl_cnt", v.tgt ? cnt_s : cnt_w, v.cnt);
            check("tbl_load_err", v.tgt ? err_s : err_w, v.err);
            check("tbl_alarm", v.tgt ? alm_s : alm_w, v.alm);
        end
    endtask

    initial begin
        logic [W-1:0] z, mx, a, a10;
        vec_t v;

        z   = pk(0, 0, 0, 0);
        mx  = pk(23, 59, 59, 9);
        a   = pk(1, 2, 3, 4);
        a10 = pk(0, 0, 1, 0);

        // r  l  e  d  load_val          alarm  tgt co       lim cnt               err alm
        tbl.push_back(mk(0, 0, 0, 1, z,                z,   0, 4'b0000, 0, z,                0, 0));
        tbl.push_back(mk(0, 0, 0, 1, z,                z,   0, 4'b0000, 0, z,                0, 0));
        tbl.push_back(mk(0, 1, 1, 1, mx,               a,   0, 4'b0000, 0, mx,               0, 0));
        tbl.push_back(mk(0, 0, 1, 1, z,                a,   0, 4'b1111, 1, z,                0, 0));
        tbl.push_back(mk(0, 0, 1, 0, z,                a,   0, 4'b1111, 1, mx,               0, 0));
        tbl.push_back(mk(0, 1, 0, 1, a10,              a,   0, 4'b0000, 1, a10,              0, 0));
        tbl.push_back(mk(0, 0, 1, 0, z,                a,   0, 4'b0001, 0, pk(0, 0, 0, 9),   0, 0));
        tbl.push_back(mk(0, 1, 1, 1, pk(12, 60, 5, 3), a,   0, 4'b0000, 0, pk(12, 0, 5, 3),  1, 0));
        tbl.push_back(mk(0, 1, 0, 1, pk(1, 1, 1, 1),   a,   0, 4'b0000, 0, pk(1, 1, 1, 1),   0, 0));
        tbl.push_back(mk(0, 1, 0, 1, z,                a10, 0, 4'b0000, 0, z,                0, 0));
        for (int s = 0; s < 10; s++)
            tbl.push_back(mk(0, 0, 1, 1, z, a10, 0, (s == 9) ? 4'b0001 : 4'b0000, 0,
                             pk(0, 0, (s + 1) / 10, (s + 1) % 10), 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, z,                a10, 0, 4'b0000, 0, a10,              0, 1));
        tbl.push_back(mk(0, 0, 0, 1, z,                a10, 0, 4'b0000, 0, a10,              0, 0));
        tbl.push_back(mk(0, 0, 0, 1, z,                a,   0, 4'b0000, 0, a10,              0, 0));
        tbl.push_back(mk(0, 0, 0, 1, z,                a10, 0, 4'b0000, 0, a10,              0, 1));
        tbl.push_back(mk(1, 1, 1, 1, pk(30, 5, 5, 5),  a10, 0, 4'b0000, 0, z,                0, 0));
        tbl.push_back(mk(0, 0, 1, 1, z,                a,   0, 4'b0000, 0, pk(0, 0, 0, 1),   0, 0));
        tbl.push_back(mk(1, 0, 1, 1, z,                a,   0, 4'b0000, 0, z,                0, 0));
        tbl.push_back(mk(0, 0, 1, 1, z,                a,   0, 4'b0000, 0, pk(0, 0, 0, 1),   0, 0));

        rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0; alarm_val = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_err[k] = 1'b0; m_alm[k] = 1'b0; m_mq[k] = 1'b1;
        end
        check("reset_cnt_w", cnt_w, '0);
        check("reset_load_err_w", err_w, 1'b0);
        check("reset_alarm_w", alm_w, 1'b0);
        check("reset_cnt_s", cnt_s, '0);

        foreach (tbl[i]) cycle(tbl[i]);

        // Saturating instance: climb onto the limit, sit there, then step back down.
        cycle(mk(0, 1, 0, 1, pk(23, 59, 59, 8), a, 1, 4'b0000, 0, pk(23, 59, 59, 8), 0, 0));
        cycle(mk(0, 0, 1, 1, z, a, 1, 4'b0000, 0, mx, 0, 0));
        for (int s = 0; s < 5; s++)
            cycle(mk(0, 0, 1, 1, z, a, 1, 4'b0000, 1, mx, 0, 0));
        cycle(mk(0, 0, 1, 0, z, a, 1, 4'b0000, 0, pk(23, 59, 59, 8), 0, 0));

        // Random traffic, biased toward loads near the limit and alarms near the count.
        for (int s = 0; s < 400; s++) begin
            v.chk  = 1'b0;
            v.tgt  = 1'b0;
            v.co   = '0; v.lim = 1'b0; v.cnt = '0; v.err = 1'b0; v.alm = 1'b0;
            v.rst  = ($urandom_range(0, 99) == 0);
            v.load = ($urandom_range(0, 9) == 0);
            v.en   = ($urandom_range(0, 3) != 0);
            v.dir  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0)
                v.lv = from_int(TOT - 1 - $urandom_range(0, 20));
            else
                v.lv = W'($urandom());
            if ($urandom_range(0, 1) == 0)
                v.av = from_int((m_n[0] + $urandom_range(0, 3)) % TOT);
            else
                v.av = W'($urandom());
            cycle(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised multi-stage cascaded counter: STAGES digit counters, each with its own modulus, chained by carry/borrow. Adds up/down counting, synchronous parallel load with range check, wrap or saturate mode, and an alarm compare. It is the general timebase/prescaler primitive for clocks, timers and frame/line counters.

## Interface
- STAGES, 4, number of cascaded stages; stage 0 is least significant.
- DW, 6, bit width of every stage field.
- MODS, {6'd24,6'd60,6'd60,6'd10}, packed STAGES*DW vector of per-stage moduli.
  - Field i is MODS[i*DW +: DW].
  - Legal range per field is 2..2**DW-1; elaboration fails otherwise.
- SATURATE, 0; 0 = wrap at limit, 1 = hold at limit.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; one step per cycle while high.
- dir  in  1  1 = up, 0 = down; sampled every cycle, may change any cycle.
- load  in  1  synchronous parallel load.
- load_val  in  STAGES*DW  value loaded, field per stage.
- alarm_val  in  STAGES*DW  alarm compare value.
- cnt  out  STAGES*DW  current count, field per stage.
- co  out  STAGES  combinational carry/borrow chain; co[i] means stages 0..i are all terminal and a step is taken.
- at_limit  out  1  combinational; all stages terminal for the current dir.
- load_err  out  1  registered pulse: the previous load had an out-of-range field.
- alarm  out  1  registered one-cycle pulse when cnt becomes equal to alarm_val.

## Operation
- Terminal condition of stage i:
  - dir=1: cnt_i == MODS_i-1.
  - dir=0: cnt_i == 0.
- Prefix terminal t[i] = AND of the stage-0..i terminal conditions.
- hold = SATURATE & at_limit & en.
- Step of stage i is enabled when en & ~hold & (i==0 | t[i-1]).
- On a step:
  - Up: a terminal stage goes to 0, otherwise it goes to cnt_i+1.
  - Down: a terminal stage goes to MODS_i-1, otherwise it goes to cnt_i-1.
- co[i] = en & ~hold & t[i]. While hold, all co bits are 0 and cnt is unchanged.
- Priority is rst > load > en.
  - load ignores en and dir.
  - co is 0 during a load cycle.
- Load range check: each field with load_val_i >= MODS_i loads 0 instead. load_err is 1 in the next cycle if any field was out of range; otherwise it is 0.
- Alarm:
  - match = (cnt == alarm_val), full-width compare.
  - match_q is a register holding the previous match.
  - alarm is registered: in cycle n+1 it equals match(n) & ~match_q(n).
  - A cnt that stays at alarm_val gives a single pulse.
  - A change of alarm_val onto the current cnt also fires.
- Arithmetic: per-stage DW-bit only; no cross-stage adders; no overflow beyond MODS_i-1 is reachable.

## Timing
- Reset (synchronous), in the cycle after rst is sampled high:
  - cnt = 0, load_err = 0, alarm = 0.
  - match_q = 1, which suppresses an alarm straight after reset.
- co and at_limit are combinational from cnt/en/dir, so they are valid in the same cycle as the step they describe.
- cnt, load_err and alarm update one cycle after the sampling edge.
- Count latency: cnt reflects a step on the edge where en=1 was sampled.
- alarm is high in the cycle after cnt first shows the match value.
- A dir change takes effect on the same edge; there is no pipeline flush.
- Load and en together: the load wins and no step occurs.
- rst mid-count or mid-load: rst wins; pending load_err and alarm are cleared.

## Test plan
- Up wrap (defaults, SATURATE=0):
  - load {23,59,59,9}, then en=1, dir=1.
  - In the cycle before the edge: co=4'b1111, at_limit=1.
  - Next cnt = all 0.
- Down borrow: from cnt=0 with en=1, dir=0, co=4'b1111 and next cnt = {23,59,59,9}. From {0,0,1,0}, the next cnt is {0,0,0,9} with co=4'b0001.
- Saturate (SATURATE=1):
  - Count up into {23,59,59,9}; 5 more en cycles leave cnt unchanged with co=0 and at_limit=1.
  - dir=0 then steps to {23,59,59,8}.
- Load check:
  - load_val {12,60,5,3} gives cnt {12,0,5,3} and load_err=1 for one cycle.
  - A valid load next gives load_err=0.
- Alarm:
  - alarm_val {0,0,1,0}; count up from 0. alarm is high for exactly one cycle, one cycle after cnt={0,0,1,0}.
  - With en=0 and alarm_val={0,0,0,0}, no alarm fires after reset.
- Reset mid-operation: rst during a counting cycle and together with load gives cnt=0 next cycle, with co and alarm low.
